oam_dma_arbiter: RTL and testbench
==================================

# oam_dma_arbiter

Owns the shared 16-bit address / 8-bit data memory bus between the CPU and the OAM DMA engine. It intercepts CPU writes to the DMA register at 0xFF46 and copies 160 bytes from page XX00 into OAM at 0xFE00–0xFE9F. While the copy runs, it blocks CPU bus accesses. It sits between the CPU core and the memory/peripheral decode. The existing bus checker model attaches directly to its memory-side ports.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_address  in  16  CPU address.
- cpu_data_out  in  8  CPU write data.
- cpu_data_in  out  8  read data returned to CPU.
- cpu_nread / cpu_nwrite / cpu_nsel  in  1 each  CPU strobes, active-low.
- address_bus  out  16  memory bus address.
- data_bus  inout  8  memory bus data.
- nread / nwrite / nsel  out  1 each  memory bus strobes, active-low.
- dma_active  out  1  high while a transfer is pending or running.

## Operation
- **Registers**
  - dma_src[7:0]: reset value 0xFF.
  - index[7:0]: byte counter.
  - latch[7:0]: byte holding register.
  - state: IDLE, START, READ, WRITE.
- **CPU access.** A CPU access is `cpu_nsel=0` with `cpu_nread=0` or `cpu_nwrite=0`. If both strobes are low, write wins.
- **DMA register access at 0xFF46.** Handled in every state and never forwarded to the memory bus.
  - Write: dma_src <= cpu_data_out, index <= 0, state <= START. This also restarts a running transfer.
  - Read: cpu_data_in = dma_src.
- **IDLE state.** All other CPU accesses pass through combinationally:
  - address_bus = cpu_address.
  - Strobes copy the CPU strobes.
  - On a CPU write, data_bus = cpu_data_out.
  - On a CPU read, cpu_data_in = data_bus.
- **START, READ and WRITE states.** CPU accesses other than 0xFF46 are blocked:
  - CPU writes are dropped.
  - CPU reads get 0xFF.
  - The memory bus carries only DMA traffic.
- **Effective source page.** src_eff = dma_src − 0x20 when dma_src ≥ 0xE0, else dma_src. Computed 8-bit; no other remapping.
- **START.** Memory bus idle (all strobes high). Next state is READ.
- **READ.**
  - address_bus = {src_eff, index}; nread=0, nsel=0.
  - data_bus is undriven.
  - latch <= data_bus at the rising edge.
  - Next state is WRITE.
- **WRITE.**
  - address_bus = 0xFE00 + index; nwrite=0, nsel=0; data_bus = latch.
  - If index == 159: next state IDLE.
  - Otherwise: index <= index + 1, next state READ.
  - index never exceeds 159 and never wraps.
- **data_bus drive rule.** Driven only during a forwarded CPU write or in WRITE; high-Z otherwise.
- **dma_active** = (state != IDLE).
- **Reset (asynchronous).** Forces the following immediately:
  - state IDLE, index 0, latch 0x00, dma_src 0xFF.
  - A transfer in progress is abandoned with no further bus cycles.
  - nread, nwrite and nsel are forced high while reset is low.
  - data_bus is high-Z and cpu_data_in = 0xFF while reset is low.

## Timing
- Pass-through in IDLE is zero-latency (combinational).
- DMA outputs are decoded from registered state. They are stable for the full cycle and sampled by memory at the ending rising edge.
- **Transfer timeline** (edge 0 = the edge at which the CPU write to 0xFF46 is sampled):
  - Cycle 1: START.
  - Cycles 2 + 2i: READ of byte i.
  - Cycles 3 + 2i: WRITE of byte i.
  - The last WRITE (byte 159) is cycle 321.
  - dma_active rises after edge 0 and falls after edge 321, giving 321 high cycles.
- **Restart.** A 0xFF46 write during READ or WRITE aborts that cycle's effect on the following state: the next state is START and index is 0. The in-flight bus cycle still completes as driven during the current cycle.
- **Back-to-back.** A CPU access in the cycle right after dma_active falls is forwarded normally.

## Test plan
- **Pass-through:** reset release, then CPU read 0x1234 with memory driving 0x5A -> address_bus 0x1234, nread=0, nsel=0, cpu_data_in 0x5A, dma_active 0.
- **Full copy:** CPU writes 0xC1 to 0xFF46 -> no bus cycle at 0xFF46; one idle cycle; then 160 alternating reads C100..C19F and writes FE00..FE9F. Each write data equals the byte read in the preceding cycle. dma_active high exactly 321 cycles. Reading 0xFF46 afterwards returns 0xC1.
- **Echo mapping:** write 0xE3 to 0xFF46 -> reads come from C300..C39F.
- **Blocking:** during a transfer, CPU reads 0x4000 -> cpu_data_in 0xFF and the bus shows only DMA cycles. CPU writes 0x77 to 0xC000 -> no write to 0xC000 appears. CPU reads 0xFF46 -> the current dma_src.
- **Restart:** rewrite 0xFF46 with 0xD0 while index=80 -> one START cycle, then reads restart at D000. Exactly 160 further reads; OAM is rewritten FE00..FE9F.
- **Mid-transfer reset:** assert reset during the READ of index 40 -> in the same cycle strobes go high and data_bus goes high-Z; dma_active 0. After release, a 0xFF46 read returns 0xFF and no DMA cycles occur.

Source files
------------

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: arbitrates the shared memory bus between the CPU and the
// OAM DMA engine. A CPU write to 0xFF46 starts a 160-byte copy from page
// src00 into OAM (0xFE00-0xFE9F). The CPU is locked off the bus while the
// copy runs, except for accesses to the DMA register itself.
module oam_dma_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data_out,
  output logic [7:0]  cpu_data_in,
  input  logic        cpu_nread,
  input  logic        cpu_nwrite,
  input  logic        cpu_nsel,
  output logic [15:0] address_bus,
  inout  wire  [7:0]  data_bus,
  output logic        nread,
  output logic        nwrite,
  output logic        nsel,
  output logic        dma_active
);

  localparam logic [15:0] DMA_REG  = 16'hFF46;
  localparam logic [7:0]  OAM_PAGE = 8'hFE;
  localparam logic [7:0]  LAST_IDX = 8'd159;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  index;
  logic [7:0]  index_nxt;
  logic [7:0]  dma_src;
  logic [7:0]  latch;
  logic        drv_en;
  logic [7:0]  drv_data;

  logic        cpu_wr;
  logic        cpu_rd;
  logic        reg_hit;
  logic        reg_wr;
  logic        reg_rd;

  // Pages 0xE0-0xFF mirror the work RAM 0x2000 lower (echo region).
  function automatic logic [7:0] src_page(input logic [7:0] src);
    return (src >= 8'hE0) ? (src - 8'h20) : src;
  endfunction

  // When both strobes are low the write takes precedence.
  assign cpu_wr  = !cpu_nsel && !cpu_nwrite;
  assign cpu_rd  = !cpu_nsel && !cpu_nread && cpu_nwrite;
  assign reg_hit = (cpu_address == DMA_REG);
  assign reg_wr  = reg_hit && cpu_wr;
  assign reg_rd  = reg_hit && cpu_rd;

  assign dma_active = (state != S_IDLE);

  // Only a forwarded CPU write or a DMA WRITE cycle drives the bus.
  assign data_bus = drv_en ? drv_data : 8'hzz;

  // State, counter, source page and byte latch; reset abandons any transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      index   <= 8'd0;
      latch   <= 8'h00;
      dma_src <= 8'hFF;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
      if (reg_wr) begin
        dma_src <= cpu_data_out;
      end
      if (state == S_READ) begin
        latch <= data_bus;
      end
    end
  end

  // Next-state and byte counter; a DMA register write restarts from START.
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    case (state)
      S_IDLE:  state_nxt = S_IDLE;
      S_START: state_nxt = S_READ;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: begin
        if (index == LAST_IDX) begin
          state_nxt = S_IDLE;
        end else begin
          index_nxt = index + 8'd1;
          state_nxt = S_READ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (reg_wr) begin
      state_nxt = S_START;
      index_nxt = 8'd0;
    end
  end

  // Memory-side bus: CPU pass-through in IDLE, DMA cycles otherwise.
  always_comb begin
    address_bus = 16'h0000;
    nread       = 1'b1;
    nwrite      = 1'b1;
    nsel        = 1'b1;
    drv_en      = 1'b0;
    drv_data    = latch;
    if (reset) begin
      case (state)
        S_IDLE: begin
          if (!reg_hit) begin
            address_bus = cpu_address;
            nread       = cpu_nread;
            nwrite      = cpu_nwrite;
            nsel        = cpu_nsel;
            if (cpu_wr) begin
              drv_en   = 1'b1;
              drv_data = cpu_data_out;
            end
          end
        end
        S_READ: begin
          address_bus = {src_page(dma_src), index};
          nread       = 1'b0;
          nsel        = 1'b0;
        end
        S_WRITE: begin
          address_bus = {OAM_PAGE, index};
          nwrite      = 1'b0;
          nsel        = 1'b0;
          drv_en      = 1'b1;
          drv_data    = latch;
        end
        default: begin
          address_bus = 16'h0000;
        end
      endcase
    end
  end

  // CPU read data: DMA register, forwarded memory data, or 0xFF when blocked.
  always_comb begin
    cpu_data_in = 8'hFF;
    if (reset) begin
      if (reg_rd) begin
        cpu_data_in = dma_src;
      end else if ((state == S_IDLE) && cpu_rd) begin
        cpu_data_in = data_bus;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Testbench for oam_dma_arbiter: a memory model on the bus side and a
// scoreboard queue of expected bus cycles, checked once per clock.
module tb_oam_dma_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_in;
  logic        cpu_nread;
  logic        cpu_nwrite;
  logic        cpu_nsel;
  logic [15:0] address_bus;
  wire  [7:0]  data_bus;
  logic        nread;
  logic        nwrite;
  logic        nsel;
  logic        dma_active;

  logic [7:0]  mem [0:65535];
  wire         mem_rd = !nsel && !nread && nwrite;

  typedef struct packed {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clock = ~clock;

  assign data_bus = mem_rd ? mem[address_bus] : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_bus[g]);
  end

  oam_dma_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_address  (cpu_address),
    .cpu_data_out (cpu_data_out),
    .cpu_data_in  (cpu_data_in),
    .cpu_nread    (cpu_nread),
    .cpu_nwrite   (cpu_nwrite),
    .cpu_nsel     (cpu_nsel),
    .address_bus  (address_bus),
    .data_bus     (data_bus),
    .nread        (nread),
    .nwrite       (nwrite),
    .nsel         (nsel),
    .dma_active   (dma_active)
  );

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[15:8] ^ {a[6:0], a[7]} ^ 8'hA5;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_nsel   = 1'b1;
    cpu_nread  = 1'b1;
    cpu_nwrite = 1'b1;
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    cpu_address = a;
    cpu_nsel    = 1'b0;
    cpu_nread   = 1'b0;
    cpu_nwrite  = 1'b1;
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_address  = a;
    cpu_data_out = d;
    cpu_nsel     = 1'b0;
    cpu_nread    = 1'b1;
    cpu_nwrite   = 1'b0;
    #1;
  endtask

  // Expected DMA traffic: n_bytes read/write pairs, optionally one more read.
  task automatic push_copy(input logic [7:0] page, input int n_bytes, input bit extra_read);
    for (int i = 0; i < n_bytes; i++) begin
      exp_q.push_back('{wr: 1'b0, a: {page, 8'(i)}, d: pat({page, 8'(i)})});
      exp_q.push_back('{wr: 1'b1, a: {8'hFE, 8'(i)}, d: pat({page, 8'(i)})});
    end
    if (extra_read) begin
      exp_q.push_back('{wr: 1'b0, a: {page, 8'(n_bytes)}, d: pat({page, 8'(n_bytes)})});
    end
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      step();
      b++;
    end
    chk("drain_queue", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic chk_oam(input logic [7:0] page);
    for (int i = 0; i < 160; i++) begin
      chk("oam_byte", {8'h00, mem[{8'hFE, 8'(i)}]}, {8'h00, pat({page, 8'(i)})});
    end
  endtask

  initial begin
    int cnt;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = pat(16'(a));
    end
    mem[16'h1234] = 8'h5A;

    // Bus monitor / memory write port, sampled on the falling edge.
    fork
      forever begin
        ev_t e;
        @(negedge clock);
        if (!nsel && (!nread || !nwrite)) begin
          if (exp_q.size() == 0) begin
            chk("bus_extra_cycle", address_bus, 16'hFFFF ^ address_bus);
          end else begin
            e = exp_q.pop_front();
            chk("bus_kind", {15'd0, !nwrite}, {15'd0, e.wr});
            chk("bus_addr", address_bus, e.a);
            chk("bus_data", {8'h00, data_bus}, {8'h00, e.d});
          end
          if (!nwrite) begin
            mem[address_bus] = data_bus;
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset with CPU strobes active: outputs must stay quiet.
    reset        = 1'b0;
    cpu_address  = 16'h1234;
    cpu_data_out = 8'h00;
    cpu_nsel     = 1'b0;
    cpu_nread    = 1'b0;
    cpu_nwrite   = 1'b1;
    #12;
    chk("rst_nread", {15'd0, nread}, 16'd1);
    chk("rst_nwrite", {15'd0, nwrite}, 16'd1);
    chk("rst_nsel", {15'd0, nsel}, 16'd1);
    chk("rst_active", {15'd0, dma_active}, 16'd0);
    chk("rst_cpu_din", {8'h00, cpu_data_in}, 16'h00FF);
    chk("rst_data_bus", {8'h00, data_bus}, 16'h00FF);
    step();
    cpu_idle();
    reset = 1'b1;
    step();

    // Pass-through read and write.
    exp_q.push_back('{wr: 1'b0, a: 16'h1234, d: 8'h5A});
    cpu_rd(16'h1234);
    chk("pt_addr", address_bus, 16'h1234);
    chk("pt_nread", {15'd0, nread}, 16'd0);
    chk("pt_nsel", {15'd0, nsel}, 16'd0);
    chk("pt_cpu_din", {8'h00, cpu_data_in}, 16'h005A);
    chk("pt_active", {15'd0, dma_active}, 16'd0);
    step();
    exp_q.push_back('{wr: 1'b1, a: 16'h2000, d: 8'h99});
    cpu_wr(16'h2000, 8'h99);
    chk("pt_wdata", {8'h00, data_bus}, 16'h0099);
    step();
    cpu_idle();
    step();
    chk("pt_mem_write", {8'h00, mem[16'h2000]}, 16'h0099);

    // Full copy from page C1.
    push_copy(8'hC1, 160, 1'b0);
    cpu_wr(16'hFF46, 8'hC1);
    chk("reg_wr_nsel", {15'd0, nsel}, 16'd1);
    chk("reg_wr_bus_z", {8'h00, data_bus}, 16'h00FF);
    step();
    cpu_idle();
    chk("start_active", {15'd0, dma_active}, 16'd1);
    chk("start_idle_bus", {15'd0, nsel}, 16'd1);
    cnt = 0;
    for (int b = 0; b < 400; b++) begin
      @(negedge clock);
      if (dma_active) cnt++;
      else break;
    end
    chk("active_cycles", 16'(cnt), 16'd321);
    step();
    drain(10);
    chk_oam(8'hC1);
    cpu_rd(16'hFF46);
    chk("reg_rd_c1", {8'h00, cpu_data_in}, 16'h00C1);
    chk("reg_rd_nsel", {15'd0, nsel}, 16'd1);
    step();
    cpu_idle();
    step();

    // Echo page E3 maps to C3, with blocked CPU accesses mid-transfer.
    push_copy(8'hC3, 160, 1'b0);
    cpu_wr(16'hFF46, 8'hE3);
    step();
    cpu_idle();
    repeat (10) step();
    cpu_rd(16'h4000);
    chk("blk_rd_ff", {8'h00, cpu_data_in}, 16'h00FF);
    step();
    cpu_wr(16'hC000, 8'h77);
    step();
    cpu_rd(16'hFF46);
    chk("blk_reg_rd", {8'h00, cpu_data_in}, 16'h00E3);
    step();
    cpu_idle();
    drain(400);
    repeat (5) step();
    chk("blk_wr_dropped", {8'h00, mem[16'hC000]}, {8'h00, pat(16'hC000)});
    chk_oam(8'hC3);

    // Restart with D0 during the READ of index 80.
    push_copy(8'h80, 80, 1'b1);
    cpu_wr(16'hFF46, 8'h80);
    step();
    cpu_idle();
    repeat (161) step();
    chk("rs_at_idx80", address_bus, 16'h8050);
    chk("rs_at_read", {15'd0, nread}, 16'd0);
    push_copy(8'hD0, 160, 1'b0);
    cpu_wr(16'hFF46, 8'hD0);
    step();
    cpu_idle();
    chk("rs_start_active", {15'd0, dma_active}, 16'd1);
    chk("rs_start_idle", {15'd0, nsel}, 16'd1);
    drain(400);
    repeat (5) step();
    chk_oam(8'hD0);

    // Reset during the READ of index 40.
    push_copy(8'h50, 40, 1'b0);
    cpu_wr(16'hFF46, 8'h50);
    step();
    cpu_idle();
    repeat (81) step();
    chk("mr_at_idx40", address_bus, 16'h5028);
    chk("mr_at_read", {15'd0, nread}, 16'd0);
    reset = 1'b0;
    #1;
    chk("mr_nread", {15'd0, nread}, 16'd1);
    chk("mr_nwrite", {15'd0, nwrite}, 16'd1);
    chk("mr_nsel", {15'd0, nsel}, 16'd1);
    chk("mr_bus_z", {8'h00, data_bus}, 16'h00FF);
    chk("mr_active", {15'd0, dma_active}, 16'd0);
    chk("mr_queue", 16'(exp_q.size()), 16'd0);
    step();
    step();
    reset = 1'b1;
    cpu_rd(16'hFF46);
    chk("mr_reg_ff", {8'h00, cpu_data_in}, 16'h00FF);
    step();
    cpu_idle();
    repeat (20) step();
    chk("mr_no_dma", {15'd0, dma_active}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
